div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle sequencer for the RV32M divide/remainder datapath (DIV, DIVU, REM, REMU).
- Decode issues these with the register write deferred, so this block owns the writeback.
- Sits beside ex: accepts a start pulse with operands, holds the pipeline while iterating, then returns the result with a one-cycle register-write strobe.
- Implements a radix-2 restoring divider, one quotient bit per cycle.

Parameters:
- XLEN, 32, operand/result width
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  launch request; sampled only in IDLE
- op_i  in  3  funct3 code: DIV=100, DIVU=101, REM=110, REMU=111
- dividend_i  in  XLEN  rs1 value
- divisor_i  in  XLEN  rs2 value
- waddr_i  in  5  destination register
- flush_i  in  1  jump/flush from ex; aborts an operation in flight
- busy_o  out  1  operation in flight; drives pipeline hold
- ready_o  out  1  one-cycle result-valid strobe
- result_o  out  XLEN  quotient or remainder; valid only while ready_o
- reg_we_o  out  1  register write enable; equals ready_o
- reg_waddr_o  out  5  latched waddr_i; valid only while ready_o

Behaviour:
- Reset (async, rst_i=1): state=IDLE, counter=0, all outputs 0, all operand/result registers 0.
- States:
  - IDLE: on start_i && !flush_i, latch op, waddr and operands, then go to START. flush_i has priority over start_i.
  - START, one cycle:
    - divisor==0: quotient=all ones; remainder=dividend (raw, unsigned or signed alike); go to END.
    - DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF: quotient=0x80000000, remainder=0; go to END.
    - Otherwise: load |dividend| and |divisor| (absolute values only for signed ops); record quotient sign (signs differ) and remainder sign (dividend sign); clear partial remainder; counter=0; go to CALC.
  - CALC, XLEN cycles:
    - Each cycle: shift {rem,quot} left by 1, trial-subtract the divisor; if no borrow, keep the difference and set the quotient LSB.
    - counter increments each cycle; when counter==XLEN-1, go to END.
  - END, one cycle:
    - Apply sign correction (two's-complement negate quotient/remainder per recorded signs; skipped on the special-case paths).
    - Select quotient for DIV/DIVU, remainder for REM/REMU.
    - Assert ready_o and reg_we_o for exactly this cycle; go to IDLE.
- busy_o: 1 in START, CALC and END; 0 in IDLE.
- Latency from the start_i edge (cycle t):
  - Normal path: ready_o at t+XLEN+2, i.e. t+34.
  - Special-case path: ready_o at t+2.
- start_i while busy_o=1: ignored, no queuing.
- flush_i in START or CALC: next state IDLE, no ready_o.
- flush_i in END: ignored; the result commits, because the div is older than the jump.
- back-to-back: start_i in the cycle after END is accepted.
- All arithmetic is XLEN-bit modulo; the trial subtract is XLEN+1 bits wide to expose the borrow.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in START, if |divisor| > |dividend| (unsigned compare of the absolute values), set quotient=0 and remainder=dividend (raw), then go straight to END. ready_o arrives at t+2.
- Not defined: this case takes the full CALC path (t+34). Results are identical in both builds.

Decomposition:
- tinyriscv_pkg holds:
  - the existing INST_DIV/INST_DIVU/INST_REM/INST_REMU funct3 constants;
  - a new typedef enum logic [1:0] div_state_e {DIV_IDLE, DIV_START, DIV_CALC, DIV_END}.
- One natural combinational sub-module, div_step: takes {rem,quot} and divisor, returns the next {rem,quot}. This lets the iteration be unit-tested in isolation.

Test Plan:
- DIV 20 / -3 (0x14, 0xFFFFFFFD) -> ready_o at t+34, result_o=0xFFFFFFFA; REM on the same operands -> 0x00000002; reg_waddr_o=waddr_i.
- DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF at t+34; REMU 0xFFFFFFFF / 0x10 -> 0x0000000F.
- DIV 7 / 0 -> 0xFFFFFFFF at t+2; REMU 7 / 0 -> 0x00000007 at t+2; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, both at t+2.
- Start DIVU 100/7, assert flush_i at t+10 -> no ready_o ever, busy_o=0 at t+11. New start at t+12 returns 14 at t+46. A start_i pulse at t+5 (while busy) has no effect.
- rst_i asserted asynchronously mid-CALC -> busy_o/ready_o/reg_we_o/result_o go to 0 immediately. After release, DIV 9/2 returns 4 at t+34.
- DIVU 3/10: with DIV_EARLY_OUT_EN -> result 0 at t+2 (REMU gives 3); without it -> same values at t+34.

Source files
------------

// File: rtl/tinyriscv_pkg.sv
// Shared decode constants and divider state encoding.
package tinyriscv_pkg;

  // funct3 codes of the RV32M divide/remainder group
  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_START,
    DIV_CALC,
    DIV_END
  } div_state_e;

  // DIV/REM treat operands as two's complement
  function automatic logic div_op_signed(input logic [2:0] op);
    return (op == INST_DIV) || (op == INST_REM);
  endfunction

  // REM/REMU return the remainder instead of the quotient
  function automatic logic div_op_rem(input logic [2:0] op);
    return (op == INST_REM) || (op == INST_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem,quot} left, trial-subtract
// the divisor, keep the difference and set the quotient LSB when no borrow.
// Relies on the invariant i_rem < i_divisor, so the shifted remainder stays
// below 2*divisor and an XLEN+1 bit subtract exposes the borrow in its MSB.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quot,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quot
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_borrow;

  assign w_shift  = {i_rem, i_quot[XLEN-1]};
  assign w_diff   = w_shift - {1'b0, i_divisor};
  assign w_borrow = w_diff[XLEN];

  assign o_rem  = w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign o_quot = {i_quot[XLEN-2:0], ~w_borrow};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle RV32M divide/remainder sequencer with owned writeback.
// IDLE latches operands, START handles special cases and takes absolute
// values, CALC runs XLEN restoring steps, END fixes signs and strobes the
// register write for one cycle.
// Optional: define DIV_EARLY_OUT_EN to skip CALC when |divisor| > |dividend|.
module div_seq
  import tinyriscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      waddr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o,
  output logic            reg_we_o,
  output logic [4:0]      reg_waddr_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e r_state;
  div_state_e w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [4:0]       r_waddr;
  logic [XLEN-1:0]  r_dividend;
  logic [XLEN-1:0]  r_divisor;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quot;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_special;
  logic             r_ready;
  logic [XLEN-1:0]  r_result;
  logic [4:0]       r_waddr_out;

  logic            w_signed;
  logic            w_dvd_neg;
  logic            w_dvs_neg;
  logic [XLEN-1:0] w_dvd_abs;
  logic [XLEN-1:0] w_dvs_abs;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_early;
  logic            w_special;
  logic [XLEN-1:0] w_step_rem;
  logic [XLEN-1:0] w_step_quot;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_result;

  // Operand classification, evaluated while in START on latched operands
  assign w_signed   = div_op_signed(r_op);
  assign w_dvd_neg  = w_signed & r_dividend[XLEN-1];
  assign w_dvs_neg  = w_signed & r_divisor[XLEN-1];
  assign w_dvd_abs  = w_dvd_neg ? (~r_dividend + 1'b1) : r_dividend;
  assign w_dvs_abs  = w_dvs_neg ? (~r_divisor + 1'b1) : r_divisor;
  assign w_div_zero = (r_divisor == '0);
  assign w_ovf      = w_signed & (r_dividend == MIN_NEG) & (&r_divisor);
`ifdef DIV_EARLY_OUT_EN
  assign w_early    = (w_dvs_abs > w_dvd_abs);
`else
  assign w_early    = 1'b0;
`endif
  assign w_special  = w_div_zero | w_ovf | w_early;

  div_step #(.XLEN(XLEN)) u_step (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quot    (w_step_quot)
  );

  // Sign correction is bypassed on special paths, whose values are final
  assign w_q_fix  = (r_neg_q & ~r_special) ? (~r_quot + 1'b1) : r_quot;
  assign w_r_fix  = (r_neg_r & ~r_special) ? (~r_rem + 1'b1) : r_rem;
  assign w_result = div_op_rem(r_op) ? w_r_fix : w_q_fix;

  assign busy_o      = (r_state != DIV_IDLE);
  assign ready_o     = r_ready;
  assign reg_we_o    = r_ready;
  assign result_o    = r_result;
  assign reg_waddr_o = r_waddr_out;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= DIV_IDLE;
    else       r_state <= w_next;
  end

  // Next state: flush wins over start; END always commits
  always_comb begin
    w_next = r_state;
    case (r_state)
      DIV_IDLE:  if (start_i && !flush_i) w_next = DIV_START;
      DIV_START: begin
        if (flush_i)        w_next = DIV_IDLE;
        else if (w_special) w_next = DIV_END;
        else                w_next = DIV_CALC;
      end
      DIV_CALC: begin
        if (flush_i)                w_next = DIV_IDLE;
        else if (r_cnt == CNT_LAST) w_next = DIV_END;
      end
      DIV_END:   w_next = DIV_IDLE;
      default:   w_next = DIV_IDLE;
    endcase
  end

  // Datapath: operand latch, setup, iteration and result register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt       <= '0;
      r_op        <= '0;
      r_waddr     <= '0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_special   <= 1'b0;
      r_ready     <= 1'b0;
      r_result    <= '0;
      r_waddr_out <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        DIV_IDLE: begin
          if (start_i && !flush_i) begin
            r_op       <= op_i;
            r_waddr    <= waddr_i;
            r_dividend <= dividend_i;
            r_divisor  <= divisor_i;
          end
        end
        DIV_START: begin
          r_cnt     <= '0;
          r_special <= w_special;
          r_neg_q   <= 1'b0;
          r_neg_r   <= 1'b0;
          if (w_div_zero) begin
            r_quot <= '1;
            r_rem  <= r_dividend;
          end else if (w_ovf) begin
            r_quot <= MIN_NEG;
            r_rem  <= '0;
          end else if (w_early) begin
            r_quot <= '0;
            r_rem  <= r_dividend;
          end else begin
            r_quot    <= w_dvd_abs;
            r_rem     <= '0;
            r_divisor <= w_dvs_abs;
            r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r   <= w_dvd_neg;
          end
        end
        DIV_CALC: begin
          r_rem  <= w_step_rem;
          r_quot <= w_step_quot;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        DIV_END: begin
          r_ready     <= 1'b1;
          r_result    <= w_result;
          r_waddr_out <= r_waddr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, results, flush, reset and back-to-back.
module tb_div_seq;
  import tinyriscv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  waddr_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, ready_o, reg_we_o;
  logic [31:0] result_o;
  logic [4:0]  reg_waddr_o;

  int total = 0;
  int bad = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif

  div_seq dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .waddr_i(waddr_i),
    .flush_i(flush_i), .busy_o(busy_o), .ready_o(ready_o),
    .result_o(result_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive a one-cycle start; returns just after the accepting edge t
  task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wa);
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; waddr_i = wa;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Start an op and wait (bounded) for ready_o; lat = edges after t, -1 on timeout
  task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wa,
                       output int lat, output logic [31:0] res,
                       output logic [4:0] wadr, output logic we);
    lat = -1; res = 'x; wadr = 'x; we = 1'b0;
    start_op(op, a, b, wa);
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk_i); #1;
      if (ready_o === 1'b1) begin
        lat = i; res = result_o; wadr = reg_waddr_o; we = reg_we_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (ready_o !== 1'b0 || reg_we_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b/%b exp=0/0", ready_o, reg_we_o); end
    total++; if (result_o !== 32'h0 || reg_waddr_o !== 5'h0) begin bad++; $display("FAIL reset_result got=%h/%h exp=0/0", result_o, reg_waddr_o); end
    @(negedge clk_i); rst_i = 1'b0;
  endtask

  task automatic test_signed();
    int lat; logic [31:0] res; logic [4:0] wa; logic we;
    do_op(INST_DIV, 32'h14, 32'hFFFFFFFD, 5'd5, lat, res, wa, we);
    total++; if (lat !== 34) begin bad++; $display("FAIL div_lat got=%0d exp=34", lat); end
    total++; if (res !== 32'hFFFFFFFA) begin bad++; $display("FAIL div_res got=%h exp=fffffffa", res); end
    total++; if (wa !== 5'd5 || we !== 1'b1) begin bad++; $display("FAIL div_wb got=%0d/%b exp=5/1", wa, we); end
    @(posedge clk_i); #1;
    total++; if (ready_o !== 1'b0 || reg_we_o !== 1'b0) begin bad++; $display("FAIL ready_one_cycle got=%b/%b exp=0/0", ready_o, reg_we_o); end
    do_op(INST_REM, 32'h14, 32'hFFFFFFFD, 5'd6, lat, res, wa, we);
    total++; if (lat !== 34 || res !== 32'h2) begin bad++; $display("FAIL rem_res got=%h lat=%0d exp=00000002 lat=34", res, lat); end
    total++; if (wa !== 5'd6) begin bad++; $display("FAIL rem_waddr got=%0d exp=6", wa); end
    do_op(INST_DIV, 32'hFFFFFFF9, 32'h2, 5'd7, lat, res, wa, we);
    total++; if (lat !== 34 || res !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_neg got=%h lat=%0d exp=fffffffd lat=34", res, lat); end
    do_op(INST_REM, 32'hFFFFFFF9, 32'h2, 5'd7, lat, res, wa, we);
    total++; if (lat !== 34 || res !== 32'hFFFFFFFF) begin bad++; $display("FAIL rem_neg got=%h lat=%0d exp=ffffffff lat=34", res, lat); end
  endtask

  task automatic test_unsigned();
    int lat; logic [31:0] res; logic [4:0] wa; logic we;
    do_op(INST_DIVU, 32'hFFFFFFFF, 32'h1, 5'd1, lat, res, wa, we);
    total++; if (lat !== 34 || res !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu_max got=%h lat=%0d exp=ffffffff lat=34", res, lat); end
    do_op(INST_REMU, 32'hFFFFFFFF, 32'h10, 5'd2, lat, res, wa, we);
    total++; if (lat !== 34 || res !== 32'hF) begin bad++; $display("FAIL remu_16 got=%h lat=%0d exp=0000000f lat=34", res, lat); end
  endtask

  task automatic test_special();
    int lat; logic [31:0] res; logic [4:0] wa; logic we;
    do_op(INST_DIV, 32'h7, 32'h0, 5'd8, lat, res, wa, we);
    total++; if (lat !== 2 || res !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_by0 got=%h lat=%0d exp=ffffffff lat=2", res, lat); end
    do_op(INST_REMU, 32'h7, 32'h0, 5'd9, lat, res, wa, we);
    total++; if (lat !== 2 || res !== 32'h7) begin bad++; $display("FAIL remu_by0 got=%h lat=%0d exp=00000007 lat=2", res, lat); end
    do_op(INST_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd10, lat, res, wa, we);
    total++; if (lat !== 2 || res !== 32'h80000000) begin bad++; $display("FAIL div_ovf got=%h lat=%0d exp=80000000 lat=2", res, lat); end
    do_op(INST_REM, 32'h80000000, 32'hFFFFFFFF, 5'd11, lat, res, wa, we);
    total++; if (lat !== 2 || res !== 32'h0) begin bad++; $display("FAIL rem_ovf got=%h lat=%0d exp=00000000 lat=2", res, lat); end
  endtask

  task automatic test_flush();
    int lat; logic [31:0] res; logic [4:0] wa; logic we;
    int seen = 0;
    start_op(INST_DIVU, 32'd100, 32'd7, 5'd3);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk_i);
      start_i = (i == 5);
      if (i == 5) begin op_i = INST_DIVU; dividend_i = 32'd50; divisor_i = 32'd5; waddr_i = 5'd9; end
      flush_i = (i == 10);
      @(posedge clk_i); #1;
      if (ready_o === 1'b1) seen++;
      if (i == 6) begin
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL busy_midcalc got=%b exp=1", busy_o); end
      end
    end
    start_i = 1'b0; flush_i = 1'b0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy_o); end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_ready got=%0d strobes exp=0", seen); end
    do_op(INST_DIVU, 32'd100, 32'd7, 5'd3, lat, res, wa, we);
    total++; if (lat !== 34 || res !== 32'd14) begin bad++; $display("FAIL after_flush got=%0d lat=%0d exp=14 lat=34", res, lat); end
    total++; if (wa !== 5'd3) begin bad++; $display("FAIL after_flush_waddr got=%0d exp=3", wa); end
  endtask

  task automatic test_async_reset();
    int lat; logic [31:0] res; logic [4:0] wa; logic we;
    start_op(INST_DIV, 32'd100, 32'd3, 5'd4);
    repeat (10) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    total++; if (busy_o !== 1'b0 || ready_o !== 1'b0 || reg_we_o !== 1'b0) begin bad++; $display("FAIL arst_ctrl got=%b%b%b exp=000", busy_o, ready_o, reg_we_o); end
    total++; if (result_o !== 32'h0 || reg_waddr_o !== 5'h0) begin bad++; $display("FAIL arst_data got=%h/%h exp=0/0", result_o, reg_waddr_o); end
    @(negedge clk_i); rst_i = 1'b0;
    do_op(INST_DIV, 32'd9, 32'd2, 5'd12, lat, res, wa, we);
    total++; if (lat !== 34 || res !== 32'd4) begin bad++; $display("FAIL post_rst got=%0d lat=%0d exp=4 lat=34", res, lat); end
  endtask

  task automatic test_early_out();
    int lat; logic [31:0] res; logic [4:0] wa; logic we;
    do_op(INST_DIVU, 32'd3, 32'd10, 5'd13, lat, res, wa, we);
    total++; if (lat !== EARLY_LAT || res !== 32'd0) begin bad++; $display("FAIL early_divu got=%0d lat=%0d exp=0 lat=%0d", res, lat, EARLY_LAT); end
    do_op(INST_REMU, 32'd3, 32'd10, 5'd14, lat, res, wa, we);
    total++; if (lat !== EARLY_LAT || res !== 32'd3) begin bad++; $display("FAIL early_remu got=%0d lat=%0d exp=3 lat=%0d", res, lat, EARLY_LAT); end
    do_op(INST_REM, 32'hFFFFFFFD, 32'd5, 5'd15, lat, res, wa, we);
    total++; if (lat !== EARLY_LAT || res !== 32'hFFFFFFFD) begin bad++; $display("FAIL early_rem_neg got=%h lat=%0d exp=fffffffd lat=%0d", res, lat, EARLY_LAT); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res; logic [4:0] wa; logic we;
    do_op(INST_DIVU, 32'd6, 32'd0, 5'd16, lat, res, wa, we);
    total++; if (lat !== 2 || res !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_first got=%h lat=%0d exp=ffffffff lat=2", res, lat); end
    do_op(INST_DIVU, 32'd100, 32'd10, 5'd17, lat, res, wa, we);
    total++; if (lat !== 34 || res !== 32'd10) begin bad++; $display("FAIL b2b_second got=%0d lat=%0d exp=10 lat=34", res, lat); end
    do_op(INST_REMU, 32'd100, 32'd7, 5'd18, lat, res, wa, we);
    total++; if (lat !== 34 || res !== 32'd2 || wa !== 5'd18) begin bad++; $display("FAIL b2b_third got=%0d lat=%0d wa=%0d exp=2 lat=34 wa=18", res, lat, wa); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_special();
    test_flush();
    test_async_reset();
    test_early_out();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
